// File: rtl/i2c_slave_regfile.sv
// I2C target with a DEPTH-byte register file and auto-incrementing pointer.
// SCL/SDA are oversampled on clk; no clock stretching.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h10,
    parameter int         DEPTH       = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scl_in,
    input  logic                     sda_in,
    output logic                     sda_oe,
    input  logic [$clog2(DEPTH)-1:0] host_addr,
    output logic [7:0]               host_rdata,
    output logic                     wr_strobe,
    output logic [$clog2(DEPTH)-1:0] wr_index,
    output logic                     busy,
    output logic                     addr_hit
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RACK      = 4'd8;
    localparam logic [3:0] ST_WAIT_STOP = 4'd9;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_c, stop_c;

    logic [3:0]    state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          hit_q, hit_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [AW-1:0] wr_index_q, wr_index_d;
    logic [7:0]    byte_in;
    logic [7:0]    rd_byte;
    logic [7:0]    regs_q [DEPTH];

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign start_c  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign byte_in  = {shift_q[6:0], sda_s};
    assign rd_byte  = regs_q[ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        hit_d       = hit_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        // Bus conditions win over everything and drop any ACK/data we drive.
        if (stop_c) begin
            state_d  = ST_IDLE;
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            hit_d    = 1'b0;
        end else if (start_c) begin
            state_d  = ST_ADDR;
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
            hit_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d  = byte_in;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd7) begin
                        bitcnt_d = '0;
                        if (byte_in[7:1] == SLAVE_ADDR && SLAVE_ADDR != 7'h00) begin
                            state_d = ST_ADDR_ACK;
                            hit_d   = 1'b1;
                            rw_d    = byte_in[0];
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_PTR: if (scl_rise) begin
                    shift_d  = byte_in;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd7) begin
                        bitcnt_d = '0;
                        ptr_d    = byte_in[AW-1:0];
                        state_d  = ST_PTR_ACK;
                    end
                end
                ST_WDATA: if (scl_rise) begin
                    shift_d  = byte_in;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd7) begin
                        bitcnt_d    = '0;
                        wr_strobe_d = 1'b1;
                        wr_index_d  = ptr_q;
                        ptr_d       = ptr_q + PTR_ONE;
                        state_d     = ST_WDATA_ACK;
                    end
                end
                // First fall asserts the ACK, the second one releases it.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                    sda_oe_d = ~sda_oe_q;
                    if (sda_oe_q) begin
                        if (state_q == ST_ADDR_ACK && rw_q) begin
                            state_d  = ST_RDATA;
                            shift_d  = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                            bitcnt_d = '0;
                        end else if (state_q == ST_ADDR_ACK) begin
                            state_d = ST_PTR;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) bitcnt_d = bitcnt_q + 4'd1;
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + PTR_ONE;
                            bitcnt_d = '0;
                            state_d  = ST_RACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        if (sda_s) state_d = ST_WAIT_STOP;
                        else       bitcnt_d = 4'd1;
                    end
                    if (scl_fall && bitcnt_q != 4'd0) begin
                        state_d  = ST_RDATA;
                        shift_d  = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                        bitcnt_d = '0;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            hit_q       <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            hit_q       <= hit_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_strobe_d) begin
            regs_q[ptr_q] <= byte_in;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign host_rdata = regs_q[host_addr];
    assign wr_strobe  = wr_strobe_q;
    assign wr_index   = wr_index_q;
    assign busy       = busy_q;
    assign addr_hit   = hit_q;
endmodule
